// File: rtl/cache_pkg.sv
// Shared state encoding and geometry helpers for the line-refill engine.
// Geometry functions are constant functions so they can size ports and parameters.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INVAL  = 2'd1,
    FILL   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  function automatic int log2_min1(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

  function automatic int calc_words(input int block_size, input int data_width);
    return block_size * 8 / data_width;
  endfunction

  function automatic int calc_byte_w(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int calc_word_w(input int block_size, input int data_width);
    return log2_min1(calc_words(block_size, data_width));
  endfunction

  function automatic int calc_lines(input int cache_size, input int block_size, input int sets);
    return cache_size / (block_size * sets);
  endfunction

  function automatic int calc_idx_w(input int cache_size, input int block_size, input int sets);
    return log2_min1(calc_lines(cache_size, block_size, sets));
  endfunction

  function automatic int calc_tag_w(input int addr_width, input int data_width,
                                    input int cache_size, input int block_size,
                                    input int sets);
    return addr_width - calc_idx_w(cache_size, block_size, sets)
           - calc_word_w(block_size, data_width) - calc_byte_w(data_width);
  endfunction

endpackage

// File: rtl/refill_addr_gen.sv
// Critical-word-first address generator: wrapping word counter, beat counter,
// last-beat flag and the word-aligned memory address of the current beat.
module refill_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_W      = 26,
  parameter int IDX_W      = 2,
  parameter int WORD_W     = 2,
  parameter int BYTE_W     = 2,
  parameter int WORDS      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WORD_W-1:0]     start_word,
  input  logic [TAG_W-1:0]      tag,
  input  logic [IDX_W-1:0]      idx,
  input  logic                  advance,
  output logic [WORD_W-1:0]     word_cnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  last_beat
);

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);

  logic [WORD_W-1:0] beats;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
      beats    <= '0;
    end else if (load) begin
      word_cnt <= start_word;
      beats    <= '0;
    end else if (advance) begin
      word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
      beats    <= beats + 1'b1;
    end
  end

  assign last_beat = (beats == LAST_WORD);

  // Shift rather than concatenate zeros so an 8-bit word (BYTE_W=0) still elaborates.
  assign mem_addr = ADDR_WIDTH'({tag, idx, word_cnt}) << BYTE_W;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Line-refill engine: invalidates the victim line, bursts the block in
// critical-word-first, then commits tag+valid while stalling the requester.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CACHE_SIZE     = 128,
  parameter int BLOCK_SIZE     = 16,
  parameter int NUMBER_OF_SETS = 2,
  localparam int WORDS  = calc_words(BLOCK_SIZE, DATA_WIDTH),
  localparam int BYTE_W = calc_byte_w(DATA_WIDTH),
  localparam int WORD_W = calc_word_w(BLOCK_SIZE, DATA_WIDTH),
  localparam int IDX_W  = calc_idx_w(CACHE_SIZE, BLOCK_SIZE, NUMBER_OF_SETS),
  localparam int TAG_W  = calc_tag_w(ADDR_WIDTH, DATA_WIDTH, CACHE_SIZE, BLOCK_SIZE,
                                     NUMBER_OF_SETS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss,
  input  logic [ADDR_WIDTH-1:0]   miss_addr,
  input  logic [0:NUMBER_OF_SETS-1] set_sel,
  output logic                    mem_sel,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready,
  output logic                    cache_we,
  output logic [0:NUMBER_OF_SETS-1] cache_way,
  output logic [IDX_W-1:0]        cache_index,
  output logic [WORD_W-1:0]       cache_word,
  output logic [DATA_WIDTH-1:0]   cache_wdata,
  output logic [TAG_W-1:0]        cache_tag,
  output logic                    valid_clr,
  output logic                    tag_we,
  output logic                    wait_req,
  output logic                    refill_done,
  output state_t                  fsm_state
);

  localparam int WAY_W = log2_min1(NUMBER_OF_SETS);

  // Memory handshake: mem_sel with a stable mem_addr is the request; a beat
  // transfers in any FILL cycle where mem_ready is high, and mem_rdata is
  // written to the data array in that same cycle.

  state_t state, state_next;

  logic                             load;
  logic                             advance;
  logic                             last_beat;
  logic [WORD_W-1:0]                word_cnt;
  logic [WAY_W-1:0]                 way_idx;
  logic [0:NUMBER_OF_SETS-1]        way_pick;
  logic                             unused_addr_bits;

  assign unused_addr_bits = ^miss_addr;

  // Lowest-index set bit wins; an all-zero select falls back to way 0.
  always_comb begin
    way_idx  = '0;
    way_pick = '0;
    for (int i = NUMBER_OF_SETS - 1; i >= 0; i--) begin
      if (set_sel[i]) way_idx = WAY_W'(i);
    end
    way_pick[way_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load        = 1'b0;
    advance     = 1'b0;
    mem_sel     = 1'b0;
    cache_we    = 1'b0;
    valid_clr   = 1'b0;
    tag_we      = 1'b0;
    wait_req    = 1'b0;
    refill_done = 1'b0;
    case (state)
      IDLE: begin
        wait_req = miss & ~rst;
        if (miss) begin
          load       = 1'b1;
          state_next = INVAL;
        end
      end
      INVAL: begin
        valid_clr  = 1'b1;
        wait_req   = 1'b1;
        state_next = FILL;
      end
      FILL: begin
        mem_sel  = 1'b1;
        wait_req = 1'b1;
        if (mem_ready) begin
          cache_we = 1'b1;
          advance  = 1'b1;
          if (last_beat) state_next = COMMIT;
        end
      end
      COMMIT: begin
        tag_we      = 1'b1;
        refill_done = 1'b1;
        wait_req    = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Line identity is captured once at miss acceptance; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_tag   <= '0;
      cache_index <= '0;
      cache_way   <= '0;
    end else if (load) begin
      cache_tag   <= miss_addr[ADDR_WIDTH-1 -: TAG_W];
      cache_index <= miss_addr[BYTE_W+WORD_W +: IDX_W];
      cache_way   <= way_pick;
    end
  end

  refill_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TAG_W      (TAG_W),
    .IDX_W      (IDX_W),
    .WORD_W     (WORD_W),
    .BYTE_W     (BYTE_W),
    .WORDS      (WORDS)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .start_word (miss_addr[BYTE_W +: WORD_W]),
    .tag        (cache_tag),
    .idx        (cache_index),
    .advance    (advance),
    .word_cnt   (word_cnt),
    .mem_addr   (mem_addr),
    .last_beat  (last_beat)
  );

  assign cache_word  = word_cnt;
  assign cache_wdata = mem_rdata;
  assign fsm_state   = state;

endmodule
